axi_lite_slave_bridge: RTL and testbench

//   AXI4-Lite responder: lets an external AXI4-Lite master reach the unified system's internal req/ack bus.

---
 rtl/axi_lite_slave_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_slave_bridge.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_bridge.sv
// AXI4-Lite responder that turns each AXI transaction into one access on the internal req/ack bus.
// One transaction at a time; address decode, strobe/alignment checks and the access timeout live here.
module axi_lite_slave_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 32'h0001_0000,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]              axi_awprot,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]              axi_arprot,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic                    int_req,
  output logic                    int_we,
  output logic [ADDR_WIDTH-1:0]   int_addr,
  output logic [DATA_WIDTH-1:0]   int_wdata,
  input  logic                    int_ack,
  input  logic [DATA_WIDTH-1:0]   int_rdata,
  output logic [15:0]             timeout_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_ACCESS,
    WR_RESP,
    RD_ACCESS,
    RD_RESP
  } state_t;

  state_t                  state;
  logic                    aw_done;
  logic                    w_done;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]   w_strb_q;
  logic [CNT_WIDTH-1:0]    wait_cnt;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic                    have_aw;
  logic                    have_w;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_WIDTH-1:0]   wr_strb;
  logic [1:0]              wr_check;
  logic [1:0]              rd_check;
  logic                    unused_prot;

  // Offset compare avoids overflow when the window touches the top of the address space.
  function automatic logic [1:0] check_resp(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic                  strb_ok);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDR;
    if (addr < BASE_ADDR || offset >= ADDR_SPAN)
      check_resp = RESP_DECERR;
    else if (addr[1:0] != 2'b00 || !strb_ok)
      check_resp = RESP_SLVERR;
    else
      check_resp = RESP_OKAY;
  endfunction

  always_comb begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_arready = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          axi_awready = 1'b1;
          axi_wready  = 1'b1;
          axi_arready = !axi_awvalid && !axi_wvalid;
        end
        WR_COLLECT: begin
          axi_awready = !aw_done;
          axi_wready  = !w_done;
        end
        default: ;
      endcase
    end
  end

  assign aw_hs    = axi_awvalid && axi_awready;
  assign w_hs     = axi_wvalid && axi_wready;
  assign ar_hs    = axi_arvalid && axi_arready;
  assign have_aw  = aw_done || aw_hs;
  assign have_w   = w_done || w_hs;
  assign wr_addr  = aw_done ? aw_addr_q : axi_awaddr;
  assign wr_data  = w_done ? w_data_q : axi_wdata;
  assign wr_strb  = w_done ? w_strb_q : axi_wstrb;
  assign wr_check = check_resp(wr_addr, &wr_strb);
  assign rd_check = check_resp(axi_araddr, 1'b1);

  assign unused_prot = ^{axi_awprot, axi_arprot};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      wait_cnt      <= '0;
      axi_bresp     <= RESP_OKAY;
      axi_bvalid    <= 1'b0;
      axi_rdata     <= '0;
      axi_rresp     <= RESP_OKAY;
      axi_rvalid    <= 1'b0;
      int_req       <= 1'b0;
      int_we        <= 1'b0;
      int_addr      <= '0;
      int_wdata     <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE, WR_COLLECT: begin
          if (have_aw && have_w) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (wr_check != RESP_OKAY) begin
              axi_bresp  <= wr_check;
              axi_bvalid <= 1'b1;
              state      <= WR_RESP;
            end else begin
              int_req   <= 1'b1;
              int_we    <= 1'b1;
              int_addr  <= wr_addr;
              int_wdata <= wr_data;
              wait_cnt  <= '0;
              state     <= WR_ACCESS;
            end
          end else if (aw_hs || w_hs) begin
            if (aw_hs) begin
              aw_done   <= 1'b1;
              aw_addr_q <= axi_awaddr;
            end
            if (w_hs) begin
              w_done   <= 1'b1;
              w_data_q <= axi_wdata;
              w_strb_q <= axi_wstrb;
            end
            state <= WR_COLLECT;
          end else if (ar_hs) begin
            if (rd_check != RESP_OKAY) begin
              axi_rresp  <= rd_check;
              axi_rdata  <= '0;
              axi_rvalid <= 1'b1;
              state      <= RD_RESP;
            end else begin
              int_req  <= 1'b1;
              int_we   <= 1'b0;
              int_addr <= axi_araddr;
              wait_cnt <= '0;
              state    <= RD_ACCESS;
            end
          end
        end

        // An ack in the timeout cycle still counts as a successful access.
        WR_ACCESS, RD_ACCESS: begin
          if (int_ack || wait_cnt == CNT_LAST) begin
            int_req <= 1'b0;
            if (!int_ack && timeout_count != 16'hFFFF)
              timeout_count <= timeout_count + 16'd1;
            if (state == WR_ACCESS) begin
              axi_bresp  <= int_ack ? RESP_OKAY : RESP_SLVERR;
              axi_bvalid <= 1'b1;
              state      <= WR_RESP;
            end else begin
              axi_rresp  <= int_ack ? RESP_OKAY : RESP_SLVERR;
              axi_rdata  <= int_ack ? int_rdata : '0;
              axi_rvalid <= 1'b1;
              state      <= RD_RESP;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end

        WR_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            state      <= IDLE;
          end
        end

        RD_RESP: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
// Scoreboard bench for axi_lite_slave_bridge: expectations are queued as stimulus is issued
// and retired by a monitor when the internal bus or the AXI response channels fire.
module tb_axi_lite_slave_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic [2:0]  axi_awprot = 3'b010;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic [2:0]  axi_arprot = 3'b001;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic        int_req;
  logic        int_we;
  logic [31:0] int_addr;
  logic [31:0] int_wdata;
  logic        int_ack;
  logic [31:0] int_rdata;
  logic [15:0] timeout_count;

  logic        resp_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] resp_rdata = '0;
  assign int_ack   = resp_ack | force_ack;
  assign int_rdata = resp_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  strb;
  } vec_t;

  acc_t exp_acc[$];
  rsp_t exp_b[$];
  rsp_t exp_r[$];
  acc_t mon_acc;
  rsp_t mon_rsp;
  vec_t vecs[6];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          ack_en = 1'b1;
  int          ack_delay = 1;
  int          req_seen = 0;
  logic [31:0] rdata_val = '0;
  int          req_rises = 0;
  int          exp_req_total = 0;
  int          req_start = 0;
  int          last_req_len = 0;
  logic        prev_req = 1'b0;
  logic        prev_bvalid = 1'b0;
  int          bvalid_cyc = 0;
  int          aw_hs_cyc = 0;
  int          b_hs_cyc = 0;
  int          ar_hs_cyc = 0;

  axi_lite_slave_bridge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axi_awaddr    (axi_awaddr),
    .axi_awprot    (axi_awprot),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .axi_bresp     (axi_bresp),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .axi_araddr    (axi_araddr),
    .axi_arprot    (axi_arprot),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_rdata     (axi_rdata),
    .axi_rresp     (axi_rresp),
    .axi_rvalid    (axi_rvalid),
    .axi_rready    (axi_rready),
    .int_req       (int_req),
    .int_we        (int_we),
    .int_addr      (int_addr),
    .int_wdata     (int_wdata),
    .int_ack       (int_ack),
    .int_rdata     (int_rdata),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [3:0] s, input bit wr);
    if (a < 32'h4000_0000 || a > 32'h4000_FFFF) return 2'b11;
    if (a[1:0] != 2'b00 || (wr && s != 4'hF)) return 2'b10;
    return 2'b00;
  endfunction

  // Internal target: acks once int_req has been high for ack_delay full cycles.
  always begin
    @(posedge clk);
    #1;
    if (!int_req) begin
      req_seen = 0;
      resp_ack = 1'b0;
    end else begin
      req_seen++;
      if (ack_en && req_seen == ack_delay + 1) begin
        resp_ack   = 1'b1;
        resp_rdata = rdata_val;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (int_req && !prev_req) begin
        req_rises++;
        req_start = cyc;
        if (exp_acc.size() == 0) begin
          checkOutput("unexpected_int_req", exp_acc.size(), 1);
        end else begin
          mon_acc = exp_acc.pop_front();
          checkOutput("int_we", int_we, mon_acc.we);
          checkOutput("int_addr", int_addr, mon_acc.addr);
          if (mon_acc.we) checkOutput("int_wdata", int_wdata, mon_acc.wdata);
        end
      end
      if (!int_req && prev_req) last_req_len = cyc - req_start;
      if (axi_bvalid && !prev_bvalid) bvalid_cyc = cyc;
      if (axi_bvalid && axi_bready) begin
        b_hs_cyc = cyc;
        if (exp_b.size() == 0) begin
          checkOutput("unexpected_b", exp_b.size(), 1);
        end else begin
          mon_rsp = exp_b.pop_front();
          checkOutput("bresp", axi_bresp, mon_rsp.resp);
        end
      end
      if (axi_rvalid && axi_rready) begin
        if (exp_r.size() == 0) begin
          checkOutput("unexpected_r", exp_r.size(), 1);
        end else begin
          mon_rsp = exp_r.pop_front();
          checkOutput("rresp", axi_rresp, mon_rsp.resp);
          checkOutput("rdata", axi_rdata, mon_rsp.data);
        end
      end
    end
    prev_req    = rst_n ? int_req : 1'b0;
    prev_bvalid = rst_n ? axi_bvalid : 1'b0;
  end

  task automatic sendAw(input int delay, input logic [31:0] addr);
    bit got = 1'b0;
    repeat (delay) @(posedge clk);
    if (delay > 0) #1;
    axi_awaddr  = addr;
    axi_awvalid = 1'b1;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (axi_awready) begin
        got = 1'b1;
        aw_hs_cyc = cyc;
      end
    end
    checkOutput("aw_handshake", got, 1);
    @(posedge clk);
    #1 axi_awvalid = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
    bit got = 1'b0;
    axi_wdata  = data;
    axi_wstrb  = strb;
    axi_wvalid = 1'b1;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (axi_wready) got = 1'b1;
    end
    checkOutput("w_handshake", got, 1);
    @(posedge clk);
    #1 axi_wvalid = 1'b0;
  endtask

  task automatic sendAr(input logic [31:0] addr);
    bit got = 1'b0;
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (axi_arready) begin
        got = 1'b1;
        ar_hs_cyc = cyc;
      end
    end
    checkOutput("ar_handshake", got, 1);
    @(posedge clk);
    #1 axi_arvalid = 1'b0;
  endtask

  task automatic recvB(input int hold, input logic [1:0] exp_resp);
    bit got = 1'b0;
    if (hold > 0) begin
      axi_bready = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
        @(negedge clk);
        if (axi_bvalid) got = 1'b1;
      end
      checkOutput("bvalid_arrive", got, 1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("bvalid_hold", axi_bvalid, 1);
        checkOutput("bresp_hold", axi_bresp, exp_resp);
        checkOutput("arready_hold", axi_arready, 0);
      end
      @(posedge clk);
      #1 got = 1'b0;
    end
    axi_bready = 1'b1;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (axi_bvalid) got = 1'b1;
    end
    checkOutput("b_handshake", got, 1);
    @(posedge clk);
    #1 axi_bready = 1'b0;
  endtask

  task automatic recvR(input int hold, input logic [1:0] exp_resp);
    bit got = 1'b0;
    if (hold > 0) begin
      axi_rready = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
        @(negedge clk);
        if (axi_rvalid) got = 1'b1;
      end
      checkOutput("rvalid_arrive", got, 1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("rvalid_hold", axi_rvalid, 1);
        checkOutput("rresp_hold", axi_rresp, exp_resp);
      end
      @(posedge clk);
      #1 got = 1'b0;
    end
    axi_rready = 1'b1;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (axi_rvalid) got = 1'b1;
    end
    checkOutput("r_handshake", got, 1);
    @(posedge clk);
    #1 axi_rready = 1'b0;
  endtask

  // Queue the expected results, then run the requested AXI channels concurrently.
  task automatic applyStimulus(input bit do_wr, input bit do_rd,
                               input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [31:0] raddr,
                               input int aw_delay, input int hold);
    logic [1:0]  wr_exp;
    logic [1:0]  rd_exp;
    logic [31:0] rd_data;
    wr_exp = 2'b00;
    rd_exp = 2'b00;
    if (do_wr) begin
      wr_exp = model_resp(waddr, wstrb, 1'b1);
      if (wr_exp == 2'b00) begin
        exp_acc.push_back('{1'b1, waddr, wdata});
        exp_req_total++;
        if (!ack_en) wr_exp = 2'b10;
      end
      exp_b.push_back('{wr_exp, 32'h0});
    end
    if (do_rd) begin
      rd_exp  = model_resp(raddr, 4'hF, 1'b0);
      rd_data = 32'h0;
      if (rd_exp == 2'b00) begin
        exp_acc.push_back('{1'b0, raddr, 32'h0});
        exp_req_total++;
        if (ack_en) rd_data = rdata_val;
        else rd_exp = 2'b10;
      end
      exp_r.push_back('{rd_exp, rd_data});
    end
    fork
      begin if (do_wr) sendAw(aw_delay, waddr); end
      begin if (do_wr) sendW(wdata, wstrb); end
      begin if (do_rd) sendAr(raddr); end
      begin if (do_wr) recvB(hold, wr_exp); end
      begin if (do_rd) recvR(hold, rd_exp); end
    join
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctrl"},
                {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                 int_req, int_we, axi_bresp, axi_rresp}, 0);
    checkOutput({tag, "_int_bus"}, {int_addr, int_wdata}, 0);
    checkOutput({tag, "_rdata_tcount"}, {axi_rdata, timeout_count}, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    checkResetState("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] write with AW and W together");
    applyStimulus(1'b1, 1'b0, 32'h4000_0010, 32'hCAFE_BABE, 4'hF, 32'h0, 0, 0);
    checkOutput("wr_latency", bvalid_cyc - aw_hs_cyc, 3);
    checkOutput("wr_req_len", last_req_len, 2);

    $display("[TB] W ahead of AW, then read back");
    applyStimulus(1'b1, 1'b0, 32'h4000_0010, 32'h0BAD_F00D, 4'hF, 32'h0, 3, 0);
    rdata_val = 32'h1234_5678;
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h4000_0010, 0, 0);
    checkOutput("req_count_basic", req_rises, exp_req_total);

    $display("[TB] decode and alignment table");
    vecs[0] = '{1'b0, 32'h5000_0000, 4'hF};
    vecs[1] = '{1'b1, 32'h4000_0010, 4'h3};
    vecs[2] = '{1'b0, 32'h4001_0000, 4'hF};
    vecs[3] = '{1'b0, 32'h3FFF_FFFC, 4'hF};
    vecs[4] = '{1'b1, 32'h4000_0006, 4'hF};
    vecs[5] = '{1'b0, 32'h4000_FFFC, 4'hF};
    foreach (vecs[i]) begin
      rdata_val = $urandom;
      applyStimulus(vecs[i].wr, !vecs[i].wr, vecs[i].addr, $urandom, vecs[i].strb,
                    vecs[i].addr, 0, 0);
    end
    checkOutput("req_count_errors", req_rises, exp_req_total);

    $display("[TB] simultaneous AW, W and AR");
    rdata_val = 32'hA5A5_0001;
    applyStimulus(1'b1, 1'b1, 32'h4000_0100, 32'h1111_2222, 4'hF, 32'h4000_0104, 0, 0);
    checkOutput("ar_after_b", ar_hs_cyc > b_hs_cyc, 1);

    $display("[TB] access timeout with late ack");
    ack_en = 1'b0;
    fork
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h4000_0020, 0, 5);
      begin
        bit seen_hi = 1'b0;
        bit seen_lo = 1'b0;
        for (int n = 0; n < 1000 && !seen_hi; n++) begin
          @(negedge clk);
          if (int_req) seen_hi = 1'b1;
        end
        for (int n = 0; n < 1000 && !seen_lo; n++) begin
          @(negedge clk);
          if (!int_req) seen_lo = 1'b1;
        end
        checkOutput("timeout_req_drop", seen_hi && seen_lo, 1);
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
      end
    join
    checkOutput("timeout_len", last_req_len, 256);
    checkOutput("timeout_count", timeout_count, 1);
    ack_en = 1'b1;

    $display("[TB] bready held low");
    applyStimulus(1'b1, 1'b0, 32'h4000_0200, 32'h5555_AAAA, 4'hF, 32'h0, 0, 10);

    $display("[TB] reset during read access");
    ack_en = 1'b0;
    exp_acc.push_back('{1'b0, 32'h4000_0300, 32'h0});
    exp_req_total++;
    sendAr(32'h4000_0300);
    repeat (4) @(posedge clk);
    #1 checkOutput("req_before_reset", int_req, 1);
    #2 rst_n = 1'b0;
    #1 checkResetState("mid_reset");
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h4000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0);
    checkOutput("req_count_final", req_rises, exp_req_total);
    checkOutput("pending_expectations", exp_acc.size() + exp_b.size() + exp_r.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
